gpu_instruction_queue: RTL



---
 rtl/gpu_instruction_queue.sv | 133 +++++++++++++
 1 files changed

// File: rtl/gpu_instruction_queue.sv
// gpu_instruction_queue
//   Parametrised first-word-fall-through instruction queue. It sits between
//   the command decoder and the rasteriser dispatch. Words are packed
//   {oct,b,g,r,rad,y2,x2,y1,x1,opcode} by the instantiating block.
//
// Optional feature macro: GPU_INSTR_QUEUE_HWM_EN
//   When defined, hwm_o tracks the peak occupancy seen since reset.
//   When undefined, hwm_o is tied to 0 and no tracking register exists.
//
// Ports
//   clk           system clock; all logic runs on the rising edge
//   n_rst         synchronous, active-low reset; highest priority
//   flush_i       discard all entries; clears the pointers, count and error flags
//   push_i/data_i enqueue data_i when accepted
//   pop_i         consume the head word when accepted
//   data_o        head word; holds stale memory content while empty
//   empty_o       count_o == 0
//   full_o        count_o == DEPTH
//   almost_full_o count_o >= AF_THRESH
//   count_o       occupancy, 0..DEPTH
//   overflow_o    sticky: a push was rejected
//   underflow_o   sticky: a pop was rejected
//   hwm_o         high-water mark of count_o (0 when the feature is disabled)
module gpu_instruction_queue #(
    parameter int WORD_BITS = 79,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    // Derived from DEPTH; leave at its default.
    parameter int PTR_BITS  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [WORD_BITS-1:0] data_i,
    input  logic                 pop_i,
    output logic [WORD_BITS-1:0] data_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic [PTR_BITS:0]    count_o,
    output logic                 overflow_o,
    output logic                 underflow_o,
    output logic [PTR_BITS:0]    hwm_o
);

    localparam logic [PTR_BITS:0]   CNT_ONE   = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS:0]   CNT_DEPTH = (PTR_BITS+1)'(DEPTH);
    localparam logic [PTR_BITS:0]   CNT_AF    = (PTR_BITS+1)'(AF_THRESH);
    localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);

    logic [WORD_BITS-1:0] r_mem [DEPTH];
    logic [PTR_BITS-1:0]  r_wptr;
    logic [PTR_BITS-1:0]  r_rptr;
    logic [PTR_BITS:0]    r_count;
    logic                 r_ovf;
    logic                 r_unf;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop_acc;
    logic                 w_push_acc;
    logic [PTR_BITS:0]    w_count_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_DEPTH);

    // No bypass: a pop on an empty queue is rejected even if a push arrives.
    // A push into a full queue is accepted only when a pop frees a slot.
    assign w_pop_acc  = pop_i & ~w_empty;
    assign w_push_acc = push_i & (~w_full | w_pop_acc);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush_i) begin
            // Memory is left untouched; only the bookkeeping is discarded.
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_pop_acc) r_rptr <= r_rptr + PTR_ONE;
            r_count <= w_count_nxt;
            r_ovf   <= r_ovf | (push_i & ~w_push_acc);
            r_unf   <= r_unf | (pop_i & ~w_pop_acc);
        end
    end

`ifdef GPU_INSTR_QUEUE_HWM_EN
    logic [PTR_BITS:0] r_hwm;

    // Flush forces the next count to 0, so it can never raise the mark.
    always_ff @(posedge clk) begin
        if (!n_rst)
            r_hwm <= '0;
        else if (!flush_i && (w_count_nxt > r_hwm))
            r_hwm <= w_count_nxt;
    end

    assign hwm_o = r_hwm;
`else
    assign hwm_o = '0;
`endif

    assign data_o        = r_mem[r_rptr];
    assign empty_o       = w_empty;
    assign full_o        = w_full;
    assign almost_full_o = (r_count >= CNT_AF);
    assign count_o       = r_count;
    assign overflow_o    = r_ovf;
    assign underflow_o   = r_unf;

endmodule
